// File: rtl/decompressor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | decompressor_if : compressed-line input / reconstructed-line output bundle  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface decompressor_if #(
   parameter int LEN_ENCODE = 3
);
   logic                    en_i;
   logic [256+LEN_ENCODE-1:0] data_i;
   logic [8:0]              size_i;
   logic                    rdy_o;
   logic [255:0]            data_o;
   logic                    en_o;
   logic                    rdy_i;
   logic                    err_o;

   modport master (
      output en_i, data_i, size_i, rdy_i,
      input  rdy_o, data_o, en_o, err_o
   );

   modport slave (
      input  en_i, data_i, size_i, rdy_i,
      output rdy_o, data_o, en_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/decompressor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | decompressor : two-stage {tag, payload} line reconstruction, valid/ready    |
// | Optional build macro: DECOMP_SIZE_CHECK_EN (size_i vs. tag size -> err_o)   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module decompressor #(
   parameter int NUM_PATTERNS = 8,
   parameter int LEN_ENCODE   = $clog2(NUM_PATTERNS)
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   decompressor_if.slave      bus
);
   localparam logic [LEN_ENCODE-1:0] TAG_ZERO    = LEN_ENCODE'(0);
   localparam logic [LEN_ENCODE-1:0] TAG_REP8    = LEN_ENCODE'(1);
   localparam logic [LEN_ENCODE-1:0] TAG_REP32   = LEN_ENCODE'(2);
   localparam logic [LEN_ENCODE-1:0] TAG_REP64   = LEN_ENCODE'(3);
   localparam logic [LEN_ENCODE-1:0] TAG_BD32_8  = LEN_ENCODE'(4);
   localparam logic [LEN_ENCODE-1:0] TAG_BD32_16 = LEN_ENCODE'(5);
   localparam logic [LEN_ENCODE-1:0] TAG_BD64_32 = LEN_ENCODE'(6);

   logic                  s1_valid;
   logic [LEN_ENCODE-1:0] s1_tag;
   logic [255:0]          s1_payload;
   logic [255:0]          decoded;
   logic                  out_valid;
   logic [255:0]          out_data;
   logic                  s2_load;
   logic                  in_xfer;

   assign s2_load    = s1_valid && (!out_valid || bus.rdy_i);
   assign bus.rdy_o  = rst_n && (!s1_valid || s2_load);
   assign in_xfer    = bus.en_i && bus.rdy_o;
   assign bus.en_o   = out_valid;
   assign bus.data_o = out_data;

   always_comb begin
      decoded = '0;
      case (s1_tag)
         TAG_ZERO:  decoded = '0;
         TAG_REP8:  for (int k = 0; k < 32; k++) decoded[8*k +: 8]  = s1_payload[7:0];
         TAG_REP32: for (int k = 0; k < 8; k++)  decoded[32*k +: 32] = s1_payload[31:0];
         TAG_REP64: for (int k = 0; k < 4; k++)  decoded[64*k +: 64] = s1_payload[63:0];
         TAG_BD32_8:
            for (int k = 0; k < 8; k++)
               decoded[32*k +: 32] = s1_payload[31:0]
                                   + {{24{s1_payload[32+8*k+7]}}, s1_payload[32+8*k +: 8]};
         TAG_BD32_16:
            for (int k = 0; k < 8; k++)
               decoded[32*k +: 32] = s1_payload[31:0]
                                   + {{16{s1_payload[32+16*k+15]}}, s1_payload[32+16*k +: 16]};
         TAG_BD64_32:
            for (int j = 0; j < 4; j++)
               decoded[64*j +: 64] = s1_payload[63:0]
                                   + {{32{s1_payload[64+32*j+31]}}, s1_payload[64+32*j +: 32]};
         default:   decoded = s1_payload;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_tag     <= '0;
         s1_payload <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= decoded;
         end else if (bus.rdy_i) begin
            out_valid <= 1'b0;
         end

         if (in_xfer) begin
            s1_valid   <= 1'b1;
            s1_tag     <= bus.data_i[256 +: LEN_ENCODE];
            s1_payload <= bus.data_i[255:0];
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

`ifdef DECOMP_SIZE_CHECK_EN
   // Mismatch is resolved at capture so only one flag bit travels with the beat.
   function automatic logic [8:0] table_size(input logic [LEN_ENCODE-1:0] t);
      case (t)
         TAG_ZERO:    table_size = 9'd0;
         TAG_REP8:    table_size = 9'd8;
         TAG_REP32:   table_size = 9'd32;
         TAG_REP64:   table_size = 9'd64;
         TAG_BD32_8:  table_size = 9'd96;
         TAG_BD32_16: table_size = 9'd160;
         TAG_BD64_32: table_size = 9'd192;
         default:     table_size = 9'd256;
      endcase
   endfunction

   logic s1_err;
   logic out_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_err  <= 1'b0;
         out_err <= 1'b0;
      end else begin
         if (in_xfer)
            s1_err <= (bus.size_i != table_size(bus.data_i[256 +: LEN_ENCODE]));
         if (s2_load)
            out_err <= s1_err;
      end
   end

   assign bus.err_o = out_err;
`else
   logic unused_size;
   assign unused_size = ^bus.size_i;
   assign bus.err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decompressor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_decompressor : directed self-checking bench for decompressor             |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_decompressor;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   decompressor_if #(.LEN_ENCODE(3)) bus ();

   decompressor #(.NUM_PATTERNS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat through an idle pipeline with rdy_i high: checks the 2-cycle latency too.
   task automatic do_beat(input string name, input logic [2:0] tag, input logic [255:0] pay,
                          input logic [8:0] size, input logic [255:0] exp, input logic exp_err);
      bus.en_i   = 1'b1;
      bus.data_i = {tag, pay};
      bus.size_i = size;
      bus.rdy_i  = 1'b1;
      #1;
      chk({name, "_rdy"}, 256'(bus.rdy_o), 256'd1);
      tick();
      bus.en_i = 1'b0;
      #1;
      chk({name, "_en_n1"}, 256'(bus.en_o), 256'd0);
      tick();
      chk({name, "_en_n2"}, 256'(bus.en_o), 256'd1);
      chk({name, "_data"}, bus.data_o, exp);
      chk({name, "_err"}, 256'(bus.err_o), 256'(exp_err));
      tick();
      chk({name, "_en_done"}, 256'(bus.en_o), 256'd0);
   endtask

   logic [255:0] exp_q[$];
   logic [255:0] held;
   logic [255:0] raw_line;
   logic [15:0]  rdy_pat;
   logic         stalled;
   logic         size_err_exp;
   int           sent;
   int           received;

   initial begin
      tests = 0;
      fails = 0;
      raw_line = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_5A5A5A5AA5A5A5A5;
`ifdef DECOMP_SIZE_CHECK_EN
      size_err_exp = 1'b1;
`else
      size_err_exp = 1'b0;
`endif

      // Reset held for two cycles with a beat offered
      rst_n      = 1'b0;
      bus.en_i   = 1'b1;
      bus.data_i = {3'd7, raw_line};
      bus.size_i = 9'd256;
      bus.rdy_i  = 1'b1;
      tick();
      tick();
      chk("rst_rdy", 256'(bus.rdy_o), 256'd0);
      chk("rst_en", 256'(bus.en_o), 256'd0);
      chk("rst_data", bus.data_o, 256'd0);
      chk("rst_err", 256'(bus.err_o), 256'd0);
      rst_n    = 1'b1;
      bus.en_i = 1'b0;
      #1;
      chk("post_rst_rdy", 256'(bus.rdy_o), 256'd1);
      tick();

      // Every tag
      do_beat("zero", 3'd0, {256{1'b1}}, 9'd0, 256'd0, 1'b0);
      do_beat("rep8", 3'd1, 256'hA5, 9'd8, {32{8'hA5}}, 1'b0);
      do_beat("rep32", 3'd2, 256'hDEADBEEF, 9'd32, {8{32'hDEADBEEF}}, 1'b0);
      do_beat("rep64", 3'd3, 256'h0123456789ABCDEF, 9'd64, {4{64'h0123456789ABCDEF}}, 1'b0);
      do_beat("bd32_8", 3'd4, {160'd0, 64'h10FE02807F00FF01, 32'h00000010}, 9'd96,
              {32'h20, 32'h0E, 32'h12, 32'hFFFFFF90, 32'h8F, 32'h10, 32'h0F, 32'h11}, 1'b0);
      do_beat("bd32_16_wrap", 3'd5, {208'd0, 16'h0001, 32'hFFFFFFFF}, 9'd160,
              {{7{32'hFFFFFFFF}}, 32'h0}, 1'b0);
      do_beat("bd64_32_wrap", 3'd6, {160'd0, 32'hFFFFFFFF, 64'h8000000000000000}, 9'd192,
              {{3{64'h8000000000000000}}, 64'h7FFFFFFFFFFFFFFF}, 1'b0);
      do_beat("raw", 3'd7, raw_line, 9'd256, raw_line, 1'b0);

      // Size check
      do_beat("size_ok", 3'd2, 256'h12345678, 9'd32, {8{32'h12345678}}, 1'b0);
      do_beat("size_bad", 3'd2, 256'h12345678, 9'd64, {8{32'h12345678}}, size_err_exp);

      // Fill with rdy_i low: two beats accepted, then rdy_o drops
      bus.rdy_i  = 1'b0;
      bus.en_i   = 1'b1;
      bus.size_i = 9'd32;
      bus.data_i = {3'd2, 256'hAAAA0001};
      tick();
      bus.data_i = {3'd2, 256'hAAAA0002};
      #1;
      chk("fill_rdy1", 256'(bus.rdy_o), 256'd1);
      tick();
      chk("fill_rdy_drop", 256'(bus.rdy_o), 256'd0);
      chk("fill_head", bus.data_o, {8{32'hAAAA0001}});
      bus.data_i = {3'd2, 256'hAAAA0003};
      tick();
      tick();
      chk("stall_hold", bus.data_o, {8{32'hAAAA0001}});
      chk("stall_en", 256'(bus.en_o), 256'd1);
      bus.en_i  = 1'b0;
      bus.rdy_i = 1'b1;
      #1;
      chk("drain_rdy", 256'(bus.rdy_o), 256'd1);
      tick();
      chk("drain_b", bus.data_o, {8{32'hAAAA0002}});
      tick();
      chk("drain_empty", 256'(bus.en_o), 256'd0);

      // 10-beat stream under a pseudo-random rdy_i pattern
      rdy_pat  = 16'b1011_0011_1000_1011;
      sent     = 0;
      received = 0;
      stalled  = 1'b0;
      held     = '0;
      for (int c = 0; c < 200 && received < 10; c++) begin
         bus.en_i   = (sent < 10);
         bus.data_i = {3'd2, 224'd0, 32'h1000 + 32'(sent)};
         bus.size_i = 9'd32;
         bus.rdy_i  = rdy_pat[c % 16];
         #1;
         if (stalled) chk("stream_stable", bus.data_o, held);
         if (bus.en_o && bus.rdy_i) begin
            if (exp_q.size() == 0) chk("stream_extra", bus.data_o, 256'd0);
            else chk("stream_data", bus.data_o, exp_q.pop_front());
            received++;
         end
         if (bus.en_i && bus.rdy_o) begin
            exp_q.push_back({8{32'h1000 + 32'(sent)}});
            sent++;
         end
         stalled = bus.en_o && !bus.rdy_i;
         held    = bus.data_o;
         tick();
      end
      chk("stream_count", 256'(received), 256'd10);
      bus.en_i  = 1'b0;
      bus.rdy_i = 1'b1;
      #1;
      chk("stream_nodup", 256'(bus.en_o), 256'd0);

      // Reset with both stages full
      bus.rdy_i  = 1'b0;
      bus.en_i   = 1'b1;
      bus.data_i = {3'd1, 256'h11};
      tick();
      bus.data_i = {3'd1, 256'h22};
      tick();
      bus.en_i = 1'b0;
      rst_n    = 1'b0;
      tick();
      chk("mid_rst_en", 256'(bus.en_o), 256'd0);
      chk("mid_rst_rdy", 256'(bus.rdy_o), 256'd0);
      rst_n     = 1'b1;
      bus.rdy_i = 1'b1;
      tick();
      chk("after_rst_en1", 256'(bus.en_o), 256'd0);
      tick();
      chk("after_rst_en2", 256'(bus.en_o), 256'd0);
      do_beat("after_rst_beat", 3'd1, 256'h3C, 9'd8, {32{8'h3C}}, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
